// File: rtl/res_collector_pkg.sv
// Shared types and widths for the result collector.
package res_collector_pkg;

    typedef enum logic {COLLECT = 1'b0, DRAIN = 1'b1} state_t;

    localparam int unsigned CNT_W_DEF = 10;
    localparam int unsigned CNT16_W   = 16;

endpackage

// File: rtl/res_collector_buf.sv
// res_buf: NUM x ITEM_WIDTH register array, one write port and one combinational read port.
module res_buf #(
    parameter int unsigned NUM        = 1000,
    parameter int unsigned ITEM_WIDTH = 8,
    parameter int unsigned AW         = 10
) (
    input  logic                  clk_i,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [ITEM_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [ITEM_WIDTH-1:0] o_rdata
);

    logic [ITEM_WIDTH-1:0] r_mem [NUM];

    // Contents need no reset: a batch is always fully written before it is read.
    always_ff @(posedge clk_i) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/res_collector.sv
// Collects NUM result samples into a batch, then drains the batch over valid/ready.
// Optional per-batch sum output enabled by defining RES_COLLECTOR_SUM_EN.
module res_collector
    import res_collector_pkg::*;
#(
    parameter  int unsigned NUM        = 1000,
    parameter  int unsigned ITEM_WIDTH = 8,
    localparam int unsigned CNT_W      = $clog2(NUM),
    localparam int unsigned SUM_W      = ITEM_WIDTH + CNT_W + 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  in_valid_i,
    input  logic [ITEM_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    output logic [ITEM_WIDTH-1:0] out_data_o,
    input  logic                  out_ready_i,
    output logic                  out_last_o,
    output logic                  busy_o,
    output logic [CNT16_W-1:0]    batch_cnt_o,
    output logic [CNT16_W-1:0]    drop_cnt_o
`ifdef RES_COLLECTOR_SUM_EN
    ,
    output logic [SUM_W-1:0]      batch_sum_o
`endif
);

    localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(NUM - 1);
    localparam logic [CNT16_W-1:0] CNT_MAX  = '1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_rd_ptr;
    logic [CNT16_W-1:0]    r_batch_cnt;
    logic [CNT16_W-1:0]    r_drop_cnt;
    logic [ITEM_WIDTH-1:0] w_rdata;
    logic                  w_wr_fire;
    logic                  w_wr_last;
    logic                  w_rd_fire;
    logic                  w_rd_last;
    logic                  w_drop;

    assign w_wr_fire = (r_state == COLLECT) && in_valid_i;
    assign w_wr_last = w_wr_fire && (r_wr_ptr == LAST_IDX);
    assign w_rd_fire = (r_state == DRAIN) && out_ready_i;
    assign w_rd_last = w_rd_fire && (r_rd_ptr == LAST_IDX);
    assign w_drop    = (r_state == DRAIN) && in_valid_i;

    res_buf #(
        .NUM        (NUM),
        .ITEM_WIDTH (ITEM_WIDTH),
        .AW         (CNT_W)
    ) u_buf (
        .clk_i   (clk_i),
        .i_we    (w_wr_fire),
        .i_waddr (r_wr_ptr),
        .i_wdata (in_data_i),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            COLLECT: if (w_wr_last) w_state_nxt = DRAIN;
            DRAIN:   if (w_rd_last) w_state_nxt = COLLECT;
            default: w_state_nxt = COLLECT;
        endcase
    end

    // Stream outputs decode the state register; data is forced to 0 outside DRAIN.
    always_comb begin
        out_valid_o = 1'b0;
        out_last_o  = 1'b0;
        busy_o      = 1'b0;
        out_data_o  = '0;
        if (r_state == DRAIN) begin
            out_valid_o = 1'b1;
            busy_o      = 1'b1;
            out_data_o  = w_rdata;
            out_last_o  = (r_rd_ptr == LAST_IDX);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_batch_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= w_wr_last ? '0 : r_wr_ptr + CNT_W'(1);
            end
            if (w_rd_fire) begin
                r_rd_ptr <= w_rd_last ? '0 : r_rd_ptr + CNT_W'(1);
            end
            if (w_rd_last) begin
                r_batch_cnt <= r_batch_cnt + CNT16_W'(1);
            end
            if (w_drop && (r_drop_cnt != CNT_MAX)) begin
                r_drop_cnt <= r_drop_cnt + CNT16_W'(1);
            end
        end
    end

    assign batch_cnt_o = r_batch_cnt;
    assign drop_cnt_o  = r_drop_cnt;

`ifdef RES_COLLECTOR_SUM_EN
    logic [SUM_W-1:0] r_acc;
    logic [SUM_W-1:0] r_batch_sum;
    logic [SUM_W-1:0] w_acc_nxt;

    assign w_acc_nxt = r_acc + SUM_W'(in_data_i);

    // Accumulator restarts on the final write; the completed total is held until the next batch fills.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_acc       <= '0;
            r_batch_sum <= '0;
        end else if (w_wr_last) begin
            r_acc       <= '0;
            r_batch_sum <= w_acc_nxt;
        end else if (w_wr_fire) begin
            r_acc       <= w_acc_nxt;
        end
    end

    assign batch_sum_o = r_batch_sum;
`endif

endmodule
